// File: rtl/accum_dump.sv
// accum_dump: integrate-and-dump decimator, sums DECIM samples into a full-precision result.
// Define ACCUM_DUMP_SKID_EN to replace the single result register with a 2-entry output FIFO.
module accum_dump #(
    parameter int unsigned WIDTH_IN  = 16,
    parameter int unsigned DECIM     = 8,
    parameter int unsigned IS_SIGNED = 1,
    localparam int unsigned WIDTH_OUT = WIDTH_IN + $clog2(DECIM)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clr,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH_IN-1:0]  din,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH_OUT-1:0] dout
);

    localparam int unsigned      CNT_W    = $clog2(DECIM);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);

    logic [WIDTH_OUT-1:0] acc;
    logic [WIDTH_OUT-1:0] din_ext;
    logic [WIDTH_OUT-1:0] sum;
    logic [CNT_W-1:0]     cnt;
    logic                 rdy_en;
    logic                 last;
    logic                 accept;
    logic                 dump;
    logic                 pop;
    logic                 buffer_full;

    // Extend the sample to result width according to its number format
    always_comb begin
        din_ext = WIDTH_OUT'(din);
        if (IS_SIGNED != 0) begin
            din_ext = WIDTH_OUT'($signed(din));
        end
    end

    assign sum    = acc + din_ext;
    assign last   = (cnt == CNT_LAST);
    // Only the block's last sample can stall, and only if its result has nowhere to go
    assign in_ready = rdy_en && !(last && buffer_full && !out_ready);
    assign accept = in_valid && in_ready;
    assign dump   = accept && last;
    assign pop    = out_valid && out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc    <= '0;
            cnt    <= '0;
            rdy_en <= 1'b0;
        end else begin
            rdy_en <= 1'b1;
            if (clr) begin
                acc <= '0;
                cnt <= '0;
            end else if (accept) begin
                if (last) begin
                    acc <= '0;
                    cnt <= '0;
                end else begin
                    acc <= sum;
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

`ifdef ACCUM_DUMP_SKID_EN
    logic [WIDTH_OUT-1:0] tail;
    logic                 tail_valid;

    assign buffer_full = out_valid && tail_valid;

    // dout is the FIFO head; tail only fills while the head is still pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout       <= '0;
            out_valid  <= 1'b0;
            tail       <= '0;
            tail_valid <= 1'b0;
        end else if (clr) begin
            out_valid  <= 1'b0;
            tail_valid <= 1'b0;
        end else if (dump && pop) begin
            if (tail_valid) begin
                dout <= tail;
                tail <= sum;
            end else begin
                dout <= sum;
            end
        end else if (dump) begin
            if (out_valid) begin
                tail       <= sum;
                tail_valid <= 1'b1;
            end else begin
                dout      <= sum;
                out_valid <= 1'b1;
            end
        end else if (pop) begin
            dout       <= tail;
            out_valid  <= tail_valid;
            tail_valid <= 1'b0;
        end
    end
`else
    assign buffer_full = out_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout      <= '0;
            out_valid <= 1'b0;
        end else if (clr) begin
            out_valid <= 1'b0;
        end else if (dump) begin
            dout      <= sum;
            out_valid <= 1'b1;
        end else if (pop) begin
            out_valid <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_accum_dump.sv
// tb_accum_dump: scoreboard bench for accum_dump, signed and unsigned instances on one stream.
`timescale 1ns/1ps
module tb_accum_dump;

    localparam int unsigned W  = 8;
    localparam int unsigned D  = 4;
    localparam int unsigned WO = 10;
`ifdef ACCUM_DUMP_SKID_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic [W-1:0]  din = '0;
    logic          in_ready_s, in_ready_u, out_valid_s, out_valid_u;
    logic [WO-1:0] dout_s, dout_u;

    int checks = 0;
    int errors = 0;
    bit done = 1'b0;

    logic [WO-1:0] q_s[$];
    logic [WO-1:0] q_u[$];
    int cnt_m = 0;
    int sum_s = 0;
    int sum_u = 0;

    always #5 clk = ~clk;

    accum_dump #(.WIDTH_IN(W), .DECIM(D), .IS_SIGNED(1)) dut_s (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_s),
        .din(din), .out_valid(out_valid_s), .out_ready(out_ready), .dout(dout_s)
    );

    accum_dump #(.WIDTH_IN(W), .DECIM(D), .IS_SIGNED(0)) dut_u (
        .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(in_ready_u),
        .din(din), .out_valid(out_valid_u), .out_ready(out_ready), .dout(dout_u)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: sampled on the falling edge, when inputs and outputs are settled
    initial forever begin
        @(negedge clk);
        if (!rst_n || clr) begin
            cnt_m = 0;
            sum_s = 0;
            sum_u = 0;
            q_s.delete();
            q_u.delete();
        end else begin
            check("ovalid_s", 32'(out_valid_s), 32'(q_s.size() != 0));
            check("ovalid_u", 32'(out_valid_u), 32'(q_u.size() != 0));
            check("in_ready_s", 32'(in_ready_s),
                  32'(!(cnt_m == D - 1 && q_s.size() == DEPTH && !out_ready)));
            check("in_ready_u", 32'(in_ready_u),
                  32'(!(cnt_m == D - 1 && q_u.size() == DEPTH && !out_ready)));
            if (out_valid_s && out_ready && q_s.size() != 0) check("dout_s", 32'(dout_s), 32'(q_s.pop_front()));
            if (out_valid_u && out_ready && q_u.size() != 0) check("dout_u", 32'(dout_u), 32'(q_u.pop_front()));
            if (in_valid && in_ready_s) begin
                sum_s += int'($signed(din));
                sum_u += int'(din);
                if (cnt_m == D - 1) begin
                    q_s.push_back(WO'(sum_s));
                    q_u.push_back(WO'(sum_u));
                    cnt_m = 0;
                    sum_s = 0;
                    sum_u = 0;
                end else begin
                    cnt_m++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [W-1:0] v);
        bit taken = 1'b0;
        in_valid = 1'b1;
        din = v;
        for (int i = 0; i < 200 && !taken; i++) begin
            @(negedge clk);
            taken = in_ready_s;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!taken) check("send_timeout", 32'd0, 32'd1);
    endtask

    task automatic block(input logic [W-1:0] v);
        repeat (D) send(v);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && (q_s.size() != 0 || q_u.size() != 0); i++) idle(1);
        check("drain", 32'(q_s.size() + q_u.size()), 32'd0);
    endtask

    initial begin
        bit stalled;
        repeat (2) @(negedge clk);
        check("rst_ovalid", 32'(out_valid_s), 32'd0);
        check("rst_dout", 32'(dout_s), 32'd0);
        check("rst_in_ready", 32'(in_ready_s), 32'd0);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rdy_after_rst", 32'(in_ready_s), 32'd1);

        // Basic sums and extremes
        send(8'd1); send(8'd2); send(8'd3); send(8'd4);
        drain();
        block(8'h80);
        block(8'd127);
        block(8'hFF);
        block(8'd0);
        drain();

        // Back-pressure across two blocks
        out_ready = 1'b0;
        repeat (2 * D - 1) send(8'd1);
        in_valid = 1'b1;
        din = 8'd1;
        @(negedge clk);
        stalled = !in_ready_s;
        check("stall", 32'(stalled), 32'(DEPTH == 1));
        @(posedge clk);
        #1;
        idle(2);
        out_ready = 1'b1;
        if (stalled) send(8'd1);
        in_valid = 1'b0;
        drain();

        // Clear mid-block, then clear a pending result
        send(8'd5); send(8'd5);
        clr = 1'b1;
        in_valid = 1'b1;
        din = 8'd9;
        idle(1);
        clr = 1'b0;
        in_valid = 1'b0;
        block(8'd1);
        drain();
        out_ready = 1'b0;
        block(8'd3);
        idle(1);
        check("pend_ovalid", 32'(out_valid_s), 32'd1);
        clr = 1'b1;
        idle(1);
        clr = 1'b0;
        check("clr_ovalid", 32'(out_valid_s), 32'd0);
        out_ready = 1'b1;
        idle(2);

        // Asynchronous reset with a pending result and a partial block
        out_ready = 1'b0;
        block(8'd2);
        send(8'd2); send(8'd2);
        #2 rst_n = 1'b0;
        #1;
        check("arst_ovalid", 32'(out_valid_s), 32'd0);
        check("arst_dout", 32'(dout_s), 32'd0);
        check("arst_in_ready", 32'(in_ready_s), 32'd0);
        check("arst_ovalid_u", 32'(out_valid_u), 32'd0);
        @(negedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        block(8'd2);
        drain();

        // Random gaps on both sides
        fork
            begin
                for (int b = 0; b < 30; b++) begin
                    for (int k = 0; k < D; k++) begin
                        idle($urandom_range(0, 2));
                        send(W'($urandom));
                    end
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    out_ready = 1'($urandom_range(0, 1));
                    idle(1);
                end
            end
        join
        out_ready = 1'b1;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
